// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default PC source indices, exception state and reset vector.
package cpu_pkg;

    localparam int PCSRC_ALU_RESULT = 0;
    localparam int PCSRC_ALU_OUT    = 1;
    localparam int PCSRC_JUMP       = 2;
    localparam int PCSRC_EPC        = 3;
    localparam int PCSRC_EXC        = 4;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    typedef enum logic {
        NORMAL  = 1'b0,
        HANDLER = 1'b1
    } exc_state_e;

endpackage

// File: rtl/pc_update_unit_if.sv
// Control-side bundle of the PC update unit: source selection, write enables and status.
interface pc_update_unit_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_SOURCES = 5,
    parameter int SEL_WIDTH   = 3
);
    logic [SEL_WIDTH-1:0]              pc_source;
    logic [NUM_SOURCES*DATA_WIDTH-1:0] sources;
    logic                              pc_write;
    logic                              pc_write_cond;
    logic                              branch_taken;
    logic [DATA_WIDTH-1:0]             epc_in;
    logic [DATA_WIDTH-1:0]             pc_out;
    logic [DATA_WIDTH-1:0]             epc_out;
    logic [DATA_WIDTH-1:0]             next_pc;
    logic                              in_handler;
    logic                              addr_error;
    logic                              sel_error;
    logic                              double_fault;

    modport master (
        output pc_source, sources, pc_write, pc_write_cond, branch_taken, epc_in,
        input  pc_out, epc_out, next_pc, in_handler, addr_error, sel_error, double_fault
    );

    modport slave (
        input  pc_source, sources, pc_write, pc_write_cond, branch_taken, epc_in,
        output pc_out, epc_out, next_pc, in_handler, addr_error, sel_error, double_fault
    );
endinterface

// File: rtl/pc_source_select.sv
// Combinational N:1 selector over a flattened source bus; out-of-range index yields 0.
module pc_source_select #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_SOURCES = 5,
    parameter int SEL_WIDTH   = 3
) (
    input  logic [SEL_WIDTH-1:0]              sel_i,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] sources_i,
    output logic [DATA_WIDTH-1:0]             data_o,
    output logic                              illegal_o
);

    always_comb begin
        data_o    = '0;
        illegal_o = 1'b1;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (sel_i == SEL_WIDTH'(i)) begin
                data_o    = sources_i[i*DATA_WIDTH +: DATA_WIDTH];
                illegal_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pc_update_unit.sv
// Owns PC and EPC: selects the next PC, validates the write and tracks exception entry/return.
module pc_update_unit
    import cpu_pkg::*;
#(
    parameter int              DATA_WIDTH   = 32,
    parameter int              NUM_SOURCES  = 5,
    parameter int              SEL_WIDTH    = 3,
    parameter int              EXC_SOURCE   = cpu_pkg::PCSRC_EXC,
    parameter int              EPC_SOURCE   = cpu_pkg::PCSRC_EPC,
    parameter [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(cpu_pkg::RESET_VECTOR)
) (
    input logic             clk,
    input logic             reset,
    pc_update_unit_if.slave bus
);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] epc_q, epc_d;
    exc_state_e            state_q, state_d;
    logic                  addr_err_q, addr_err_d;
    logic                  sel_err_q, sel_err_d;
    logic                  dbl_fault_q, dbl_fault_d;

    logic [DATA_WIDTH-1:0] next_pc;
    logic                  sel_illegal;
    logic                  write_en;
    logic                  is_exc;
    logic                  is_eret;

    pc_source_select #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SOURCES(NUM_SOURCES),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_select (
        .sel_i    (bus.pc_source),
        .sources_i(bus.sources),
        .data_o   (next_pc),
        .illegal_o(sel_illegal)
    );

    assign write_en = bus.pc_write | (bus.pc_write_cond & bus.branch_taken);
    assign is_exc   = (bus.pc_source == SEL_WIDTH'(EXC_SOURCE));
    assign is_eret  = (bus.pc_source == SEL_WIDTH'(EPC_SOURCE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_VECTOR;
            epc_q       <= '0;
            state_q     <= NORMAL;
            addr_err_q  <= 1'b0;
            sel_err_q   <= 1'b0;
            dbl_fault_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            epc_q       <= epc_d;
            state_q     <= state_d;
            addr_err_q  <= addr_err_d;
            sel_err_q   <= sel_err_d;
            dbl_fault_q <= dbl_fault_d;
        end
    end

    // A rejected write (bad index or misaligned target) leaves PC, EPC and state untouched.
    always_comb begin
        pc_d        = pc_q;
        epc_d       = epc_q;
        state_d     = state_q;
        addr_err_d  = 1'b0;
        sel_err_d   = sel_err_q;
        dbl_fault_d = dbl_fault_q;
        if (write_en) begin
            if (sel_illegal) begin
                sel_err_d = 1'b1;
            end else if (next_pc[1:0] != 2'b00) begin
                addr_err_d = 1'b1;
            end else begin
                pc_d = next_pc;
                case (state_q)
                    NORMAL: begin
                        if (is_exc) begin
                            epc_d   = bus.epc_in;
                            state_d = HANDLER;
                        end
                    end
                    HANDLER: begin
                        if (is_eret) begin
                            state_d = NORMAL;
                        end else if (is_exc) begin
                            dbl_fault_d = 1'b1;
                        end
                    end
                    default: state_d = NORMAL;
                endcase
            end
        end
    end

    assign bus.pc_out       = pc_q;
    assign bus.epc_out      = epc_q;
    assign bus.next_pc      = next_pc;
    assign bus.in_handler   = (state_q == HANDLER);
    assign bus.addr_error   = addr_err_q;
    assign bus.sel_error    = sel_err_q;
    assign bus.double_fault = dbl_fault_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed bench for pc_update_unit: behavioural model checked every cycle plus literal spot checks.
module tb_pc_update_unit;

    logic clk;
    logic reset;
    logic checkEn;
    int   testsRun;
    int   testsFailed;

    logic [31:0] srcArr [5];

    logic [31:0] mPc;
    logic [31:0] mEpc;
    logic        mHandler;
    logic        mAddr;
    logic        mSel;
    logic        mDbl;

    pc_update_unit_if #(.DATA_WIDTH(32), .NUM_SOURCES(5), .SEL_WIDTH(3)) bus ();

    pc_update_unit dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] expectedNext(input logic [2:0] sel);
        if (sel < 3'd5) return srcArr[sel];
        return 32'h0;
    endfunction

    // Model: a write is accepted only for an in-range, word-aligned target.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mPc      <= 32'h0;
            mEpc     <= 32'h0;
            mHandler <= 1'b0;
            mAddr    <= 1'b0;
            mSel     <= 1'b0;
            mDbl     <= 1'b0;
        end else begin
            mAddr <= 1'b0;
            if (bus.pc_write || (bus.pc_write_cond && bus.branch_taken)) begin
                if (bus.pc_source >= 3'd5) begin
                    mSel <= 1'b1;
                end else if (srcArr[bus.pc_source] % 4 != 0) begin
                    mAddr <= 1'b1;
                end else begin
                    mPc <= srcArr[bus.pc_source];
                    if (bus.pc_source == 3'd4) begin
                        if (mHandler) begin
                            mDbl <= 1'b1;
                        end else begin
                            mEpc     <= bus.epc_in;
                            mHandler <= 1'b1;
                        end
                    end else if (bus.pc_source == 3'd3) begin
                        mHandler <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn && !reset) begin
            checkOutput("model pc_out",       bus.pc_out,             mPc);
            checkOutput("model epc_out",      bus.epc_out,            mEpc);
            checkOutput("model in_handler",   32'(bus.in_handler),    32'(mHandler));
            checkOutput("model addr_error",   32'(bus.addr_error),    32'(mAddr));
            checkOutput("model sel_error",    32'(bus.sel_error),     32'(mSel));
            checkOutput("model double_fault", 32'(bus.double_fault),  32'(mDbl));
            checkOutput("model next_pc",      bus.next_pc,            expectedNext(bus.pc_source));
        end
    end

    task automatic applyStimulus(input logic [2:0] sel, input logic pcw, input logic pcwc,
                                 input logic br, input logic [31:0] epcIn);
        bus.pc_source     = sel;
        bus.pc_write      = pcw;
        bus.pc_write_cond = pcwc;
        bus.branch_taken  = br;
        bus.epc_in        = epcIn;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        checkEn     = 1'b0;
        reset       = 1'b0;
        srcArr[0] = 32'h0000_0040;
        srcArr[1] = 32'h0000_0010;
        srcArr[2] = 32'h0000_0102;
        srcArr[3] = 32'h0000_0044;
        srcArr[4] = 32'h8000_0180;
        bus.sources = {srcArr[4], srcArr[3], srcArr[2], srcArr[1], srcArr[0]};
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0, 32'h0);

        #3 reset = 1'b1;
        #1;
        checkOutput("reset pc_out",     bus.pc_out,           32'h0);
        checkOutput("reset epc_out",    bus.epc_out,          32'h0);
        checkOutput("reset in_handler", 32'(bus.in_handler),  32'h0);
        checkOutput("reset flags",      {29'h0, bus.addr_error, bus.sel_error, bus.double_fault}, 32'h0);
        #8 reset = 1'b0;
        checkEn = 1'b1;
        tick();

        applyStimulus(3'd0, 1'b0, 1'b1, 1'b0, 32'h0);
        #1 checkOutput("next_pc src0", bus.next_pc, 32'h0000_0040);
        tick();
        checkOutput("cond not taken pc", bus.pc_out, 32'h0);
        applyStimulus(3'd0, 1'b0, 1'b1, 1'b1, 32'h0);
        tick();
        checkOutput("cond taken pc", bus.pc_out, 32'h0000_0040);

        applyStimulus(3'd4, 1'b1, 1'b0, 1'b0, 32'h44);
        tick();
        checkOutput("exc entry pc",      bus.pc_out,          32'h8000_0180);
        checkOutput("exc entry epc",     bus.epc_out,         32'h44);
        checkOutput("exc entry handler", 32'(bus.in_handler), 32'h1);

        applyStimulus(3'd3, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("eret pc",      bus.pc_out,          32'h44);
        checkOutput("eret handler", 32'(bus.in_handler), 32'h0);

        applyStimulus(3'd4, 1'b1, 1'b0, 1'b0, 32'h44);
        tick();
        applyStimulus(3'd4, 1'b1, 1'b0, 1'b0, 32'h99);
        tick();
        checkOutput("dbl fault flag", 32'(bus.double_fault), 32'h1);
        checkOutput("dbl fault epc",  bus.epc_out,           32'h44);
        checkOutput("dbl fault pc",   bus.pc_out,            32'h8000_0180);

        applyStimulus(3'd3, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();

        applyStimulus(3'd2, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("misaligned pc",    bus.pc_out,          32'h44);
        checkOutput("misaligned pulse", 32'(bus.addr_error), 32'h1);
        applyStimulus(3'd2, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("misaligned pulse end", 32'(bus.addr_error), 32'h0);
        checkOutput("misaligned state",     32'(bus.in_handler), 32'h0);

        applyStimulus(3'd1, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("uncond wins pc", bus.pc_out, 32'h10);

        applyStimulus(3'd6, 1'b1, 1'b0, 1'b0, 32'h0);
        #1 checkOutput("illegal next_pc", bus.next_pc, 32'h0);
        tick();
        checkOutput("illegal pc hold", bus.pc_out,         32'h10);
        checkOutput("illegal flag",    32'(bus.sel_error), 32'h1);
        applyStimulus(3'd0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("sticky sel pc",   bus.pc_out,         32'h40);
        checkOutput("sticky sel flag", 32'(bus.sel_error), 32'h1);

        applyStimulus(3'd4, 1'b1, 1'b0, 1'b0, 32'h20);
        tick();
        applyStimulus(3'd2, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("handler misaligned pulse", 32'(bus.addr_error), 32'h1);
        checkOutput("handler misaligned state", 32'(bus.in_handler), 32'h1);
        checkOutput("handler misaligned epc",   bus.epc_out,         32'h20);
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();

        #2 reset = 1'b1;
        #1;
        checkOutput("async reset pc",      bus.pc_out,           32'h0);
        checkOutput("async reset epc",     bus.epc_out,          32'h0);
        checkOutput("async reset handler", 32'(bus.in_handler),  32'h0);
        checkOutput("async reset flags",   {29'h0, bus.addr_error, bus.sel_error, bus.double_fault}, 32'h0);
        #4 reset = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/pc_update_unit.md
Name: pc_update_unit

Overview:
Parametrised successor to the PC source multiplexer: it selects the next PC from NUM_SOURCES flattened candidates and also owns the PC and EPC registers. It adds conditional (branch) write, target alignment checking, illegal-select detection and an exception/return state machine. It sits between the control unit and the memory address mux in the multicycle datapath, and replaces the standalone PC register and PC-source mux.

Parameters:
DATA_WIDTH, 32, width of PC and of every source
NUM_SOURCES, 5, number of candidate next-PC inputs
SEL_WIDTH, 3, width of pc_source; must satisfy 2**SEL_WIDTH >= NUM_SOURCES
EXC_SOURCE, 4, source index that denotes exception entry
EPC_SOURCE, 3, source index that denotes exception return (eret)
RESET_VECTOR, 32'h0000_0000, PC value after reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
pc_source  in  SEL_WIDTH  next-PC source index
sources  in  NUM_SOURCES*DATA_WIDTH  candidates; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
pc_write  in  1  unconditional PC write
pc_write_cond  in  1  conditional PC write; takes effect only when branch_taken=1
branch_taken  in  1  branch condition from the ALU zero/compare logic
epc_in  in  DATA_WIDTH  value captured into EPC on exception entry (faulting PC)
pc_out  out  DATA_WIDTH  registered PC
epc_out  out  DATA_WIDTH  registered EPC
next_pc  out  DATA_WIDTH  combinational selected source; 0 when pc_source is illegal
in_handler  out  1  high while the exception state is HANDLER
addr_error  out  1  one-cycle pulse: an attempted write had a misaligned target
sel_error  out  1  sticky: an attempted write used pc_source >= NUM_SOURCES
double_fault  out  1  sticky: exception entry while already in HANDLER

Behaviour:
- Reset values: pc_out=RESET_VECTOR, epc_out=0, state=NORMAL, addr_error=0, sel_error=0, double_fault=0. Only reset clears the sticky flags. Reset mid-operation aborts any handler state immediately.
- Define write_en = pc_write | (pc_write_cond & branch_taken).
- next_pc is combinational from pc_source; an illegal index yields 0.
- When write_en is high on a rising edge:
  - If pc_source >= NUM_SOURCES: PC holds and sel_error is set. No other effect.
  - Otherwise, if next_pc[1:0] != 0: PC holds and addr_error pulses high for exactly the next cycle. State and EPC are unchanged.
  - Otherwise: pc_out <= next_pc (latency 1 cycle), and the state machine below applies.
- When write_en is low, nothing changes except that addr_error returns to 0.
- State machine, two states, advanced only on a legal, aligned write:
  - NORMAL, pc_source==EXC_SOURCE: epc_out <= epc_in; go to HANDLER.
  - HANDLER, pc_source==EPC_SOURCE: go to NORMAL. EPC is kept.
  - HANDLER, pc_source==EXC_SOURCE: set double_fault; EPC is NOT overwritten; stay in HANDLER; PC still redirects.
  - NORMAL, pc_source==EPC_SOURCE: PC loads normally, with no state change.
  - Any other source: no state change.
- in_handler = (state==HANDLER).
- If pc_write and pc_write_cond are both high, the unconditional write wins; branch_taken is irrelevant.
- Width rules: all values are DATA_WIDTH bits with no arithmetic; PC+4 is produced externally by the ALU.

Decomposition:
- Shared package cpu_pkg holds: the default PC source index constants (PCSRC_ALU_RESULT=0, PCSRC_ALU_OUT=1, PCSRC_JUMP=2, PCSRC_EPC=3, PCSRC_EXC=4), the state enum (NORMAL, HANDLER) and RESET_VECTOR.
- One sub-module, pc_source_select: the parametrised N:1 flattened mux with an illegal-index flag, purely combinational.
- The registers and the FSM stay in pc_update_unit.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> pc_out=0, epc_out=0, in_handler=0, all flags 0 without waiting for a clock edge.
- Conditional write: pc_source=0, source0=0x40, pc_write_cond=1, branch_taken=0 -> PC unchanged. Then branch_taken=1 -> pc_out=0x40 one cycle later.
- Exception round trip:
  - pc_source=4, source4=0x8000_0180, epc_in=0x44, pc_write=1 -> pc_out=0x8000_0180, epc_out=0x44, in_handler=1.
  - Then pc_source=3, source3=0x44 -> pc_out=0x44, in_handler=0.
- Double fault: in HANDLER with epc_out=0x44, exception write with epc_in=0x99 -> double_fault=1, epc_out stays 0x44, pc_out=source4.
- Misaligned target: source2=0x102, pc_source=2, pc_write=1 -> PC holds, addr_error high for exactly one cycle, state unchanged.
- Illegal select: pc_source=6, pc_write=1 -> next_pc=0, PC holds, sel_error=1 and it stays set through later legal writes until reset.
